// File: rtl/regchain_queue_pkg.sv
// rtl/regchain_queue_pkg.sv - shared helpers for the register-chain queue
package regchain_queue_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regchain_queue_if.sv
// rtl/regchain_queue_if.sv - write/read/status bundle of the register-chain queue
interface regchain_queue_if
  import regchain_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  localparam int CW = clog2(DEPTH + 1);

  logic             flush;
  logic             we;
  logic [WIDTH-1:0] idata;
  logic             re;
  logic [WIDTH-1:0] wdata;
  logic             rvalid;
  logic             head_valid;
  logic             oready;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, we, idata, re,
    input  wdata, rvalid, head_valid, oready, full, count, overflow, underflow
  );

  modport slave (
    input  flush, we, idata, re,
    output wdata, rvalid, head_valid, oready, full, count, overflow, underflow
  );
endinterface

// File: rtl/regchain_stage.sv
// rtl/regchain_stage.sv - one payload+valid slot; load wins over clear
module regchain_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= '0;
      vout <= 1'b0;
    end else if (load) begin
      dout <= din;
      vout <= vin;
    end else if (clear) begin
      vout <= 1'b0;
    end
  end

endmodule

// File: rtl/regchain_queue.sv
// rtl/regchain_queue.sv - FIFO built from a chain of slot registers, no RAM
module regchain_queue
  import regchain_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int BREAK = 5
) (
  input logic             clk,
  input logic             rst,
  regchain_queue_if.slave q
);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] pd [DEPTH];
  logic             v  [DEPTH];
  logic [DEPTH-1:0] mv;
  logic             oready;
  logic             wacc;
  logic             racc;
  logic [WIDTH-1:0] wdata_q;
  logic             rvalid_q;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             unf;

  // Move chain is cut every BREAK slots to bound the combinational path;
  // a slot vacated by a move is cleared unless its upstream refills it.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = q.re | !v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if ((i + 1) % BREAK == 0) mv[i] = !v[i+1];
      else                      mv[i] = mv[i+1] | !v[i+1];
    end
  end

  assign oready = mv[0] | !v[0];
  assign wacc   = q.we & oready;
  assign racc   = q.re & v[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             ld;
    logic [WIDTH-1:0] din;
    logic             vin;
    if (i == 0) begin : g_in
      assign ld  = !q.flush && wacc;
      assign din = q.idata;
      assign vin = 1'b1;
    end else begin : g_mid
      assign ld  = !q.flush && mv[i-1];
      assign din = pd[i-1];
      assign vin = v[i-1];
    end
    regchain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (ld),
      .clear (q.flush | mv[i]),
      .din   (din),
      .vin   (vin),
      .dout  (pd[i]),
      .vout  (v[i])
    );
  end

  // Entries only enter at slot 0 and leave by a read, so count tracks those two events.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      cnt      <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (q.flush) begin
      rvalid_q <= 1'b0;
      cnt      <= '0;
    end else begin
      rvalid_q <= racc;
      if (racc) wdata_q <= pd[DEPTH-1];
      if (q.we && !oready) ovf <= 1'b1;
      if (q.re && !v[DEPTH-1]) unf <= 1'b1;
      cnt <= cnt + CW'(wacc) - CW'(racc);
    end
  end

  assign q.wdata      = wdata_q;
  assign q.rvalid     = rvalid_q;
  assign q.head_valid = v[DEPTH-1];
  assign q.oready     = oready;
  assign q.full       = v[0];
  assign q.count      = cnt;
  assign q.overflow   = ovf;
  assign q.underflow  = unf;

endmodule

// File: tb/tb_regchain_queue.sv
// tb/tb_regchain_queue.sv - directed self-checking bench for regchain_queue
module tb_regchain_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  regchain_queue_if #(.WIDTH(8), .DEPTH(10)) bus ();

  regchain_queue #(.WIDTH(8), .DEPTH(10), .BREAK(5)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_oready();
    for (int t = 0; t < 50 && !bus.oready; t++) step();
    chk("oready_wait", 32'(bus.oready), 1);
  endtask

  task automatic wait_head();
    for (int t = 0; t < 50 && !bus.head_valid; t++) step();
    chk("head_wait", 32'(bus.head_valid), 1);
  endtask

  int nw;
  int nr;

  initial begin
    bus.flush = 1'b0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.idata = 8'h00;

    // reset state
    step();
    step();
    chk("rst_wdata",  32'(bus.wdata), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_head",   32'(bus.head_valid), 0);
    chk("rst_count",  32'(bus.count), 0);
    chk("rst_oready", 32'(bus.oready), 1);
    chk("rst_full",   32'(bus.full), 0);
    rst = 1'b1;

    // single write latency
    bus.we = 1'b1;
    bus.idata = 8'hA5;
    step();
    bus.we = 1'b0;
    chk("lat_full", 32'(bus.full), 1);
    chk("lat_count0", 32'(bus.count), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("lat_head_low", 32'(bus.head_valid), 0);
      chk("lat_count", 32'(bus.count), 1);
    end
    step();
    chk("lat_head_high", 32'(bus.head_valid), 1);
    chk("lat_count9", 32'(bus.count), 1);
    bus.re = 1'b1;
    step();
    bus.re = 1'b0;
    chk("lat_wdata",  32'(bus.wdata), 32'hA5);
    chk("lat_rvalid", 32'(bus.rvalid), 1);
    chk("lat_count_rd", 32'(bus.count), 0);
    step();
    chk("lat_rvalid_drop", 32'(bus.rvalid), 0);

    // fill to capacity, then overflow
    for (int k = 1; k <= 10; k++) begin
      wait_oready();
      bus.we = 1'b1;
      bus.idata = 8'(k);
      step();
      bus.we = 1'b0;
    end
    chk("fill_count", 32'(bus.count), 10);
    for (int k = 0; k < 25; k++) step();
    chk("fill_oready", 32'(bus.oready), 0);
    chk("fill_full",   32'(bus.full), 1);
    chk("fill_head",   32'(bus.head_valid), 1);
    bus.we = 1'b1;
    bus.idata = 8'hFF;
    step();
    bus.we = 1'b0;
    chk("ovf_flag",  32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 10);

    // single read from full queue: break at slot 5 holds oready low for that cycle
    bus.re = 1'b1;
    #1;
    chk("brk_oready_low", 32'(bus.oready), 0);
    step();
    bus.re = 1'b0;
    #1;
    chk("brk_oready_high", 32'(bus.oready), 1);
    chk("brk_wdata",  32'(bus.wdata), 1);
    chk("brk_rvalid", 32'(bus.rvalid), 1);
    chk("brk_count",  32'(bus.count), 9);

    for (int k = 2; k <= 10; k++) begin
      wait_head();
      bus.re = 1'b1;
      step();
      bus.re = 1'b0;
      chk("drain_wdata",  32'(bus.wdata), 32'(k));
      chk("drain_rvalid", 32'(bus.rvalid), 1);
    end
    for (int k = 0; k < 12; k++) step();
    chk("drain_count", 32'(bus.count), 0);
    chk("drain_head",  32'(bus.head_valid), 0);
    chk("drain_unf",   32'(bus.underflow), 0);

    // read on empty
    bus.re = 1'b1;
    step();
    bus.re = 1'b0;
    chk("unf_flag",   32'(bus.underflow), 1);
    chk("unf_rvalid", 32'(bus.rvalid), 0);
    chk("unf_wdata",  32'(bus.wdata), 32'h0A);

    // reset clears sticky flags
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("rst2_ovf", 32'(bus.overflow), 0);
    chk("rst2_unf", 32'(bus.underflow), 0);

    // streaming: write whenever accepted, read whenever available
    nw = 0;
    nr = 0;
    for (int c = 0; c < 3000 && nr < 64; c++) begin
      bus.re = bus.head_valid;
      #1;
      bus.we = bus.oready && (nw < 64);
      bus.idata = 8'(nw);
      if (bus.we) nw++;
      step();
      if (bus.rvalid) begin
        chk("stream_data", 32'(bus.wdata), 32'(nr));
        nr++;
      end
    end
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("stream_reads", 32'(nr), 64);
    chk("stream_ovf", 32'(bus.overflow), 0);
    chk("stream_unf", 32'(bus.underflow), 0);
    step();
    chk("stream_count", 32'(bus.count), 0);

    // flush a partly filled queue with we and re also high
    for (int k = 0; k < 5; k++) begin
      wait_oready();
      bus.we = 1'b1;
      bus.idata = 8'(8'h11 + k);
      step();
      bus.we = 1'b0;
    end
    wait_head();
    bus.re = 1'b1;
    step();
    bus.re = 1'b0;
    chk("pre_flush_wdata", 32'(bus.wdata), 32'h11);
    chk("pre_flush_count", 32'(bus.count), 4);
    bus.flush = 1'b1;
    bus.we = 1'b1;
    bus.re = 1'b1;
    bus.idata = 8'h99;
    step();
    bus.flush = 1'b0;
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("flush_count",  32'(bus.count), 0);
    chk("flush_head",   32'(bus.head_valid), 0);
    chk("flush_rvalid", 32'(bus.rvalid), 0);
    chk("flush_wdata",  32'(bus.wdata), 32'h11);
    chk("flush_full",   32'(bus.full), 0);
    chk("flush_ovf",    32'(bus.overflow), 0);
    chk("flush_unf",    32'(bus.underflow), 0);
    for (int k = 0; k < 12; k++) step();
    chk("flush_empty", 32'(bus.head_valid), 0);

    // reset mid-transfer overrides flush, we and re
    bus.re = 1'b1;
    step();
    chk("mid_unf_set", 32'(bus.underflow), 1);
    bus.re = 1'b0;
    bus.we = 1'b1;
    bus.idata = 8'h77;
    step();
    bus.we = 1'b0;
    step();
    rst = 1'b0;
    bus.we = 1'b1;
    bus.re = 1'b1;
    bus.flush = 1'b1;
    step();
    chk("mid_unf",   32'(bus.underflow), 0);
    chk("mid_wdata", 32'(bus.wdata), 0);
    chk("mid_count", 32'(bus.count), 0);
    chk("mid_full",  32'(bus.full), 0);
    rst = 1'b1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.flush = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("mid_head", 32'(bus.head_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
